div_sign_ctrl: RTL and testbench

Request/response front-end for the iterative unsigned divider in the M-extension datapath. Accepts DIV/DIVU/REM/REMU requests from the execute stage and converts signed operands to magnitudes. Drives the divider's start/operand inputs, consumes its done/quotient/remainder outputs, applies sign correction, and returns one result over a valid/ready handshake. Divide-by-zero and signed overflow are resolved locally without starting the divider.

---
 rtl/div_sign_ctrl.sv | 162 ++++++++++++++++
 tb/tb_div_sign_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sign_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_sign_ctrl
// Description : Request/response front-end for the iterative unsigned divider.
//               Converts signed DIV/REM operands to magnitudes, starts the
//               divider, and sign-corrects its quotient/remainder. Divide by
//               zero and signed overflow are answered without the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sign_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] opr1_i,
    input  logic [XLEN-1:0] opr2_i,
    input  logic            flush_i,
    output logic            div_start_o,
    output logic [XLEN-1:0] div_opr1_o,
    output logic [XLEN-1:0] div_opr2_o,
    input  logic            div_done_i,
    input  logic [XLEN-1:0] div_quo_i,
    input  logic [XLEN-1:0] div_rem_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_result_o
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_RESP  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;

    localparam logic [XLEN-1:0] c_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      r_state;
    logic            r_is_rem;
    logic            r_s1;
    logic            r_s2;
    logic [XLEN-1:0] r_opr1;
    logic [XLEN-1:0] r_opr2;
    logic [XLEN-1:0] r_result;

    // Decode of the incoming request (only meaningful while idle)
    logic            w_accept;
    logic            w_signed;
    logic            w_is_rem;
    logic            w_s1;
    logic            w_s2;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;

    // Sign correction of the divider output
    logic [XLEN-1:0] w_sel;
    logic            w_neg;
    logic [XLEN-1:0] w_fixed;

    // Flush wins over a simultaneous request in IDLE
    assign w_accept      = (r_state == c_IDLE) && req_valid_i && !flush_i;
    assign w_signed      = ~op_i[0];
    assign w_is_rem      = op_i[1];
    assign w_s1          = w_signed & opr1_i[XLEN-1];
    assign w_s2          = w_signed & opr2_i[XLEN-1];
    assign w_div_zero    = (opr2_i == '0);
    assign w_overflow    = w_signed && (opr1_i == c_MIN) && (opr2_i == c_ONES);
    assign w_special     = w_div_zero || w_overflow;
    assign w_special_res = w_div_zero ? (w_is_rem ? opr1_i : c_ONES)
                                      : (w_is_rem ? '0     : c_MIN);
    // Negating the most negative value wraps back to itself, which is the
    // correct unsigned magnitude.
    assign w_mag1        = w_s1 ? -opr1_i : opr1_i;
    assign w_mag2        = w_s2 ? -opr2_i : opr2_i;

    // Quotient takes the xor of the operand signs, remainder follows dividend
    assign w_sel         = r_is_rem ? div_rem_i : div_quo_i;
    assign w_neg         = r_is_rem ? r_s1 : (r_s1 ^ r_s2);
    assign w_fixed       = w_neg ? -w_sel : w_sel;

    // Control FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state <= w_special ? c_RESP : c_START;
                    end
                end
                c_START: begin
                    r_state <= flush_i ? c_DRAIN : c_WAIT;
                end
                c_WAIT: begin
                    // A done arriving together with flush is already consumed,
                    // so there is nothing left to drain.
                    if (flush_i) begin
                        r_state <= div_done_i ? c_IDLE : c_DRAIN;
                    end else if (div_done_i) begin
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (flush_i || rsp_ready_i) begin
                        r_state <= c_IDLE;
                    end
                end
                c_DRAIN: begin
                    if (div_done_i) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Operand capture, sign flags and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_rem <= 1'b0;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_opr1   <= '0;
            r_opr2   <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_is_rem <= w_is_rem;
                r_s1     <= w_s1;
                r_s2     <= w_s2;
                if (w_special) begin
                    r_result <= w_special_res;
                end else begin
                    r_opr1 <= w_mag1;
                    r_opr2 <= w_mag2;
                end
            end else if ((r_state == c_WAIT) && div_done_i && !flush_i) begin
                r_result <= w_fixed;
            end
        end
    end

    assign req_ready_o  = (r_state == c_IDLE);
    assign div_start_o  = (r_state == c_START);
    assign rsp_valid_o  = (r_state == c_RESP);
    assign div_opr1_o   = r_opr1;
    assign div_opr2_o   = r_opr2;
    assign rsp_result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_sign_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sign_ctrl
// Description : Self-checking bench for div_sign_ctrl with a behavioural
//               divider and a signed-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sign_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic [1:0]  op = 2'b00;
    logic [31:0] opr1 = '0;
    logic [31:0] opr2 = '0;
    logic        flush = 1'b0;
    logic        div_start_o;
    logic [31:0] div_opr1_o;
    logic [31:0] div_opr2_o;
    logic        div_done = 1'b0;
    logic [31:0] div_quo = '0;
    logic [31:0] div_rem = '0;
    logic        rsp_valid_o;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result_o;

    int n_vec = 0;
    int n_err = 0;
    int lat_force = 0;
    int done_cnt = 0;

    logic [31:0] dm_a, dm_b;
    int          dm_lat;

    div_sign_ctrl #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .op_i         (op),
        .opr1_i       (opr1),
        .opr2_i       (opr2),
        .flush_i      (flush),
        .div_start_o  (div_start_o),
        .div_opr1_o   (div_opr1_o),
        .div_opr2_o   (div_opr2_o),
        .div_done_i   (div_done),
        .div_quo_i    (div_quo),
        .div_rem_i    (div_rem),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Architectural result of a RISC-V M-extension divide/remainder
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa / sb;
            end
            2'b01: return (b == 0) ? 32'hFFFFFFFF : a / b;
            2'b10: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    endfunction

    function automatic logic [31:0] magnitude(input bit sgn, input logic [31:0] v);
        int sv;
        sv = v;
        if (sgn && sv < 0) return 32'(0 - v);
        return v;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(1, 20);
            4: return 32'(0 - $urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Behavioural unsigned divider with variable latency
    initial begin
        forever begin
            @(negedge clk);
            if (div_start_o === 1'b1) begin
                dm_a   = div_opr1_o;
                dm_b   = div_opr2_o;
                dm_lat = (lat_force > 0) ? lat_force : int'($urandom_range(1, 5));
                repeat (dm_lat) @(negedge clk);
                div_quo  = (dm_b == 0) ? 32'hFFFFFFFF : dm_a / dm_b;
                div_rem  = (dm_b == 0) ? dm_a : dm_a % dm_b;
                div_done = 1'b1;
                done_cnt++;
                @(negedge clk);
                div_done = 1'b0;
                div_quo  = $urandom;
                div_rem  = $urandom;
            end
        end
    end

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (req_ready_o !== 1'b1 && cyc < 60) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("wait_req_ready", req_ready_o, 1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp;
        bit          spec;
        int          cyc;
        exp  = ref_result(o, a, b);
        spec = is_special(o, a, b);
        wait_idle();
        req_valid = 1'b1;
        op        = o;
        opr1      = a;
        opr2      = b;
        @(negedge clk); #1;
        req_valid = 1'b0;
        opr1      = $urandom;
        opr2      = $urandom;
        if (spec) begin
            check("special_valid_n1", rsp_valid_o, 1);
            check("special_no_start", div_start_o, 0);
        end else begin
            check("start_n1", div_start_o, 1);
            check("mag1", div_opr1_o, magnitude(!o[0], a));
            check("mag2", div_opr2_o, magnitude(!o[0], b));
            check("busy_not_ready", req_ready_o, 0);
            cyc = 0;
            while (rsp_valid_o !== 1'b1 && cyc < 40) begin
                @(negedge clk); #1;
                cyc++;
            end
        end
        check("rsp_valid", rsp_valid_o, 1);
        check($sformatf("result op%0d %08h/%08h", o, a, b), rsp_result_o, exp);
        repeat (hold) begin
            @(negedge clk); #1;
            check("hold_valid", rsp_valid_o, 1);
            check("hold_result", rsp_result_o, exp);
            check("hold_not_ready", req_ready_o, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid_o, 0);
        check("post_rsp_ready", req_ready_o, 1);
    endtask

    // Global time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc;
        int  d0;
        bit  bad;
        #2;
        check("reset_req_ready", req_ready_o, 1);
        check("reset_start", div_start_o, 0);
        check("reset_opr1", div_opr1_o, 0);
        check("reset_opr2", div_opr2_o, 0);
        check("reset_rsp_valid", rsp_valid_o, 0);
        check("reset_result", rsp_result_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;

        run_op(2'b00, 32'hFFFFFFF9, 32'h2, 0);
        run_op(2'b10, 32'hFFFFFFF9, 32'h2, 0);
        run_op(2'b01, 32'd100, 32'd7, 0);
        run_op(2'b11, 32'd100, 32'd7, 0);
        run_op(2'b01, 32'hFFFFFFF9, 32'h2, 0);
        run_op(2'b00, 32'd5, 32'd0, 0);
        run_op(2'b10, 32'd5, 32'd0, 0);
        run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(2'b00, 32'h80000000, 32'h3, 0);
        run_op(2'b00, 32'd100, 32'hFFFFFFF9, 5);

        // Flush in IDLE blocks acceptance of a simultaneous request
        wait_idle();
        req_valid = 1'b1; op = 2'b01; opr1 = 32'd50; opr2 = 32'd5; flush = 1'b1;
        @(negedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("idle_flush_no_start", div_start_o, 0);
        check("idle_flush_ready", req_ready_o, 1);

        // Flush in WAIT: drain the stale done, never respond
        lat_force = 8;
        wait_idle();
        d0 = done_cnt;
        req_valid = 1'b1; op = 2'b00; opr1 = 32'd100; opr2 = 32'd7;
        @(negedge clk); #1;
        req_valid = 1'b0;
        check("flush_start", div_start_o, 1);
        @(negedge clk); #1;
        flush = 1'b1;
        @(negedge clk); #1;
        flush = 1'b0;
        bad = 0;
        cyc = 0;
        while (req_ready_o !== 1'b1 && cyc < 30) begin
            if (rsp_valid_o !== 1'b0) bad = 1;
            @(negedge clk); #1;
            cyc++;
        end
        check("drain_no_rsp", 32'(bad), 0);
        check("drain_held_cycles", 32'(cyc >= 5), 1);
        check("drain_done_consumed", done_cnt - d0, 1);
        lat_force = 0;
        run_op(2'b01, 32'd9, 32'd3, 0);

        // Asynchronous reset in WAIT; the late done must be ignored
        lat_force = 10;
        wait_idle();
        req_valid = 1'b1; op = 2'b00; opr1 = 32'hFFFFFF00; opr2 = 32'd3;
        @(negedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_req_ready", req_ready_o, 1);
        check("arst_start", div_start_o, 0);
        check("arst_opr1", div_opr1_o, 0);
        check("arst_opr2", div_opr2_o, 0);
        check("arst_rsp_valid", rsp_valid_o, 0);
        check("arst_result", rsp_result_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        bad = 0;
        repeat (15) begin
            if (rsp_valid_o !== 1'b0 || div_start_o !== 1'b0) bad = 1;
            @(negedge clk); #1;
        end
        check("arst_late_done_ignored", 32'(bad), 0);
        check("arst_idle_ready", req_ready_o, 1);
        lat_force = 0;

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            run_op(2'($urandom_range(0, 3)), pick_val(), pick_val(), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
